// File: rtl/freq_detector.sv
// -----------------------------------------------------------------------------
// freq_detector
//
// Purpose:
//   Measures the period of a divided-clock signal (sigin) in clkin cycles and
//   locks onto one of four divide codes (/2, /4, /8, /16). A code is reported
//   only after it has been measured on two consecutive periods. Illegal
//   periods and loss of sigin (timeout) are flagged with a one-cycle err pulse.
//
// Parameters:
//   TOUT     clkin cycles without a detected sigin rise that count as a
//            timeout (legal range 17..31; the counter saturates at 31).
//
// Ports:
//   clkin    in   1  system clock, all state updates on its rising edge
//   reset    in   1  asynchronous, active-high reset
//   sigin    in   1  signal under measurement, asynchronous to clkin
//   freq     out  2  locked divide code (00:/2, 01:/4, 10:/8, 11:/16)
//   valid    out  1  high while freq holds a locked, confirmed code
//   period   out  5  last measured sigin period in clkin cycles
//   err      out  1  one-cycle pulse on an illegal period or a timeout
//   changed  out  1  one-cycle pulse when freq takes a new locked value
// -----------------------------------------------------------------------------
module freq_detector #(
    parameter int TOUT = 31
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       sigin,
    output logic [1:0] freq,
    output logic       valid,
    output logic [4:0] period,
    output logic       err,
    output logic       changed
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [4:0] TOUT_C  = 5'(TOUT);
    localparam logic [4:0] CNT_MAX = 5'd31;

    // -------------------------------------------------------------------------
    // Input synchronizer and rise detector
    // -------------------------------------------------------------------------
    logic s1_q, s2_q, s3_q;
    logic rise;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sigin;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [1:0] cand_q, cand_d;
    logic [1:0] freq_q, freq_d;
    logic [4:0] period_q, period_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       changed_q, changed_d;
    // Set once freq holds a code that was actually locked. The reset value of
    // freq (00) is not a lock result, so the first lock after reset always
    // counts as a new value and pulses changed, even when it locks to 00.
    logic       locked_once_q, locked_once_d;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cand_q        <= '0;
            freq_q        <= '0;
            period_q      <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            changed_q     <= 1'b0;
            locked_once_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            freq_q        <= freq_d;
            period_q      <= period_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            changed_q     <= changed_d;
            locked_once_q <= locked_once_d;
        end
    end

    // -------------------------------------------------------------------------
    // Period classification. The counter value at a rise (before it reloads)
    // is the period just completed.
    // -------------------------------------------------------------------------
    logic [1:0] code;
    logic       legal;

    always_comb begin
        code  = 2'b00;
        legal = 1'b1;
        case (cnt_q)
            5'd2:    code = 2'b00;
            5'd4:    code = 2'b01;
            5'd8:    code = 2'b10;
            5'd16:   code = 2'b11;
            default: legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        freq_d        = freq_q;
        period_d      = period_q;
        valid_d       = valid_q;
        err_d         = 1'b0;
        changed_d     = 1'b0;
        locked_once_d = locked_once_q;

        if (state_q == IDLE) begin
            cnt_d = '0;
            if (rise) begin
                state_d = MEASURE;
                cnt_d   = 5'd1;
            end
        end else if (rise) begin
            // A rise wins over a timeout falling on the same edge.
            cnt_d    = 5'd1;
            period_d = cnt_q;
            case (state_q)
                MEASURE: begin
                    if (legal) begin
                        cand_d  = code;
                        state_d = CONFIRM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CONFIRM: begin
                    if (!legal) begin
                        err_d   = 1'b1;
                        state_d = MEASURE;
                    end else if (code == cand_q) begin
                        state_d       = LOCKED;
                        valid_d       = 1'b1;
                        freq_d        = cand_q;
                        changed_d     = !locked_once_q || (freq_q != cand_q);
                        locked_once_d = 1'b1;
                    end else begin
                        cand_d = code;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = MEASURE;
                    end else if (code != freq_q) begin
                        // freq keeps the old code until the new one confirms.
                        valid_d = 1'b0;
                        cand_d  = code;
                        state_d = CONFIRM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (cnt_q >= TOUT_C) begin
            // sigin lost: drop back to IDLE, keep the last locked code.
            err_d   = 1'b1;
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    assign freq    = freq_q;
    assign valid   = valid_q;
    assign period  = period_q;
    assign err     = err_q;
    assign changed = changed_q;

endmodule
